joy_gun_integrator: RTL

Multi-axis digital-to-position integrator that turns held joystick directions into clamped gun/crosshair coordinates for light-gun arcade cores. It sits between the hps_io joystick word and the game core's gun_h/gun_v inputs, and steps on the core's 4 ms timebase. It supersedes the fixed 2-axis, 6-bit, single-speed gun logic with these additions:
- parametrised axis count and width;
- two-speed acceleration;
- recentring;
- a slew-limited absolute (analog) mode.

---
 rtl/joy_gun_pkg.sv | 39 +++
 rtl/joy_gun_axis.sv | 145 ++++++++++++++
 rtl/joy_gun_integrator.sv | 66 ++++++
 3 files changed

// File: rtl/joy_gun_pkg.sv
// Shared types and clamp helper for the joystick-to-gun position integrator.
package joy_gun_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } axis_state_t;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_t;

    // Working width of the clamp arithmetic. Positions up to 16 bits are
    // zero-extended into it, so pos + delta can never wrap.
    localparam int CLAMP_W = 17;

    // Move pos by delta in direction dir, saturating at hi (increment)
    // or lo (decrement). Equal lo/hi turns it into "step toward a target".
    function automatic logic [CLAMP_W-1:0] clamp_add(
        input logic [CLAMP_W-1:0] pos,
        input logic [CLAMP_W-1:0] delta,
        input logic [CLAMP_W-1:0] lo,
        input logic [CLAMP_W-1:0] hi,
        input dir_t               dir
    );
        logic [CLAMP_W-1:0] sum;
        logic [CLAMP_W-1:0] res;
        sum = pos + delta;
        if (dir == DIR_INC) begin
            res = (sum > hi) ? hi : sum;
        end else begin
            res = (pos < (lo + delta)) ? lo : (pos - delta);
        end
        return res;
    endfunction

endpackage

// File: rtl/joy_gun_axis.sv
// One integrator axis: acceleration state machine, divider/step counters,
// clamped stepping and analog slew tracking.
module joy_gun_axis
    import joy_gun_pkg::*;
#(
    parameter int POS_W       = 6,
    parameter int POS_MAX     = 62,
    parameter int CENTER      = 31,
    parameter int DIV_SLOW    = 3,
    parameter int ACCEL_STEPS = 8,
    parameter int STEP_FAST   = 2
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             strobe,
    input  logic             recenter,
    input  logic             abs_mode,
    input  logic             dec,
    input  logic             inc,
    input  logic [POS_W-1:0] analog,
    output logic [POS_W-1:0] pos,
    output logic             moved
);

    localparam int DIV_W  = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;
    localparam int STEP_W = $clog2(ACCEL_STEPS + 1);

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV_SLOW - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(ACCEL_STEPS);
    localparam logic [CLAMP_W-1:0] MAX_C      = CLAMP_W'(POS_MAX);
    localparam logic [CLAMP_W-1:0] FAST_C     = CLAMP_W'(STEP_FAST);
    localparam logic [CLAMP_W-1:0] ONE_C      = CLAMP_W'(1);
    localparam logic [CLAMP_W-1:0] ZERO_C     = CLAMP_W'(0);
    localparam logic [POS_W-1:0]   CENTER_P   = POS_W'(CENTER);

    axis_state_t         state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                moved_q, moved_d;

    logic                one_s;
    dir_t                req_dir_s;
    logic [CLAMP_W-1:0]  delta_s;
    logic [CLAMP_W-1:0]  pos_c_s;
    logic [CLAMP_W-1:0]  an_c_s;
    logic [CLAMP_W-1:0]  tgt_s;
    dir_t                slew_dir_s;
    logic [POS_W-1:0]    step_pos_s;
    logic [POS_W-1:0]    slew_pos_s;

    assign one_s      = dec ^ inc;
    assign req_dir_s  = inc ? DIR_INC : DIR_DEC;
    assign pos_c_s    = CLAMP_W'(pos_q);
    assign an_c_s     = CLAMP_W'(analog);
    assign tgt_s      = (an_c_s > MAX_C) ? MAX_C : an_c_s;
    assign slew_dir_s = (tgt_s > pos_c_s) ? DIR_INC : DIR_DEC;
    assign step_pos_s = POS_W'(clamp_add(pos_c_s, delta_s, ZERO_C, MAX_C, req_dir_s));
    assign slew_pos_s = POS_W'(clamp_add(pos_c_s, FAST_C, tgt_s, tgt_s, slew_dir_s));

    // Acceleration state machine: picks the step size for this strobe.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        div_d   = div_q;
        steps_d = steps_q;
        delta_s = ZERO_C;
        if (recenter || (strobe && (abs_mode || !one_s ||
                                    ((state_q != IDLE) && (req_dir_s != dir_q))))) begin
            // Release, chord, reversal, analog mode or recentre all restart.
            state_d = IDLE;
            div_d   = '0;
            steps_d = '0;
        end else if (strobe) begin
            case (state_q)
                IDLE: begin
                    delta_s = ONE_C;
                    dir_d   = req_dir_s;
                    div_d   = '0;
                    steps_d = STEP_W'(1);
                    state_d = (ACCEL_STEPS <= 1) ? FAST : SLOW;
                end
                SLOW: begin
                    if (div_q == DIV_LAST) begin
                        delta_s = ONE_C;
                        div_d   = '0;
                        steps_d = steps_q + STEP_W'(1);
                        state_d = ((steps_q + STEP_W'(1)) == STEP_LAST) ? FAST : SLOW;
                    end else begin
                        div_d   = div_q + DIV_W'(1);
                    end
                end
                FAST: begin
                    delta_s = FAST_C;
                end
                default: begin
                    state_d = IDLE;
                    div_d   = '0;
                    steps_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Next position: recentre beats analog tracking beats integration.
    always_comb begin
        pos_d = pos_q;
        if (recenter) begin
            pos_d = CENTER_P;
        end else if (strobe && abs_mode) begin
            pos_d = slew_pos_s;
        end else if (strobe) begin
            pos_d = step_pos_s;
        end else begin
            pos_d = pos_q;
        end
        moved_d = (pos_d != pos_q);
    end

    // Axis state and registered outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_DEC;
            div_q   <= '0;
            steps_q <= '0;
            pos_q   <= CENTER_P;
            moved_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            steps_q <= steps_d;
            pos_q   <= pos_d;
            moved_q <= moved_d;
        end
    end

    assign pos   = pos_q;
    assign moved = moved_q;

endmodule

// File: rtl/joy_gun_integrator.sv
// Joystick-to-gun integrator top: tick edge detection and per-axis fan-out.
module joy_gun_integrator
    import joy_gun_pkg::*;
#(
    parameter int N_AXES      = 2,
    parameter int POS_W       = 6,
    parameter int POS_MAX     = 62,
    parameter int CENTER      = 31,
    parameter int DIV_SLOW    = 3,
    parameter int ACCEL_STEPS = 8,
    parameter int STEP_FAST   = 2
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic [N_AXES-1:0]       dec,
    input  logic [N_AXES-1:0]       inc,
    input  logic                    recenter,
    input  logic                    abs_mode,
    input  logic [N_AXES*POS_W-1:0] analog,
    output logic [N_AXES*POS_W-1:0] pos,
    output logic [N_AXES-1:0]       moved
);

    logic tick_r;
    logic armed_q;
    logic strobe_s;

    // armed_q stays low until tick has been seen low after reset, so a tick
    // already high at reset release cannot produce a strobe.
    assign strobe_s = tick & ~tick_r & armed_q;

    // Previous tick level and arm flag for the rising-edge strobe.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tick_r  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tick_r  <= tick;
            armed_q <= armed_q | ~tick;
        end
    end

    for (genvar i = 0; i < N_AXES; i++) begin : g_axis
        joy_gun_axis #(
            .POS_W       (POS_W),
            .POS_MAX     (POS_MAX),
            .CENTER      (CENTER),
            .DIV_SLOW    (DIV_SLOW),
            .ACCEL_STEPS (ACCEL_STEPS),
            .STEP_FAST   (STEP_FAST)
        ) u_axis (
            .clk_sys  (clk_sys),
            .reset_n  (reset_n),
            .strobe   (strobe_s),
            .recenter (recenter),
            .abs_mode (abs_mode),
            .dec      (dec[i]),
            .inc      (inc[i]),
            .analog   (analog[i*POS_W +: POS_W]),
            .pos      (pos[i*POS_W +: POS_W]),
            .moved    (moved[i])
        );
    end

endmodule
